// File: rtl/operand_stage_if.sv
// rtl/operand_stage_if.sv - decode-to-execute operand stage signal bundle
interface operand_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      instr_type;
    logic            shamt_used;
    logic            inc_pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            ex_wr_en;
    logic            ex_is_load;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_data;
    logic            mem_wr_en;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] store_data;
    logic            hazard_stall;

    // Decode/execute environment side
    modport master (
        output in_valid, instr_type, shamt_used, inc_pc, rs1, rs2, rs1_data, rs2_data,
               pc, imm, ex_wr_en, ex_is_load, ex_rd, ex_data, mem_wr_en, mem_rd,
               mem_data, flush, out_ready,
        input  in_ready, out_valid, a, b, store_data, hazard_stall
    );

    // Operand stage side
    modport slave (
        input  in_valid, instr_type, shamt_used, inc_pc, rs1, rs2, rs1_data, rs2_data,
               pc, imm, ex_wr_en, ex_is_load, ex_rd, ex_data, mem_wr_en, mem_rd,
               mem_data, flush, out_ready,
        output in_ready, out_valid, a, b, store_data, hazard_stall
    );
endinterface

// File: rtl/operand_stage.sv
// rtl/operand_stage.sv - registered ALU operand builder with forwarding and load-use stall
module operand_stage #(
    parameter int XLEN          = 32,
    parameter bit FWD_EN        = 1'b1,
    parameter bit LOAD_STALL_EN = 1'b1
) (
    input logic          clk,
    input logic          rst,
    operand_stage_if.slave bus
);
    localparam logic [2:0] T_R = 3'd0;
    localparam logic [2:0] T_I = 3'd1;
    localparam logic [2:0] T_S = 3'd2;
    localparam logic [2:0] T_B = 3'd3;
    localparam logic [2:0] T_U = 3'd4;
    localparam logic [2:0] T_J = 3'd5;

    localparam logic [XLEN-1:0] LINK_STEP = XLEN'(4);

    logic            valid_q;
    logic [XLEN-1:0] a_q, b_q, sd_q;
    logic [XLEN-1:0] r1, r2;
    logic [XLEN-1:0] a_d, b_d;
    logic            rs1_used, rs2_used;
    logic            load_hit, stall, ready, capture;

    // Resolve each source: EX result beats MEM result, x0 always reads the register file
    always_comb begin
        r1 = bus.rs1_data;
        r2 = bus.rs2_data;
        if (FWD_EN && bus.rs1 != 5'd0) begin
            if (bus.ex_wr_en && bus.ex_rd == bus.rs1)
                r1 = bus.ex_data;
            else if (bus.mem_wr_en && bus.mem_rd == bus.rs1)
                r1 = bus.mem_data;
        end
        if (FWD_EN && bus.rs2 != 5'd0) begin
            if (bus.ex_wr_en && bus.ex_rd == bus.rs2)
                r2 = bus.ex_data;
            else if (bus.mem_wr_en && bus.mem_rd == bus.rs2)
                r2 = bus.mem_data;
        end
    end

    // Which sources the instruction actually reads; rs2 as a shamt is not a register read
    always_comb begin
        rs1_used = (bus.instr_type == T_R) || (bus.instr_type == T_S) ||
                   (bus.instr_type == T_B) || (bus.instr_type == T_I && !bus.inc_pc);
        rs2_used = (bus.instr_type == T_R && !bus.shamt_used) ||
                   (bus.instr_type == T_S) || (bus.instr_type == T_B);
    end

    assign load_hit = bus.ex_wr_en && bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                      ((rs1_used && bus.ex_rd == bus.rs1) || (rs2_used && bus.ex_rd == bus.rs2));
    assign stall    = LOAD_STALL_EN && bus.in_valid && load_hit;
    assign ready    = (!valid_q || bus.out_ready) && !stall;
    assign capture  = bus.in_valid && ready && !bus.flush;

    // Operand selection by instruction type; unknown types produce zero operands
    always_comb begin
        a_d = '0;
        b_d = '0;
        case (bus.instr_type)
            T_R: begin
                a_d = r1;
                b_d = bus.shamt_used ? XLEN'(bus.rs2) : r2;
            end
            T_I: begin
                a_d = bus.inc_pc ? bus.pc : r1;
                b_d = bus.inc_pc ? LINK_STEP : bus.imm;
            end
            T_S: begin
                a_d = r1;
                b_d = bus.imm;
            end
            T_B: begin
                a_d = r1;
                b_d = r2;
            end
            T_U: begin
                a_d = bus.inc_pc ? bus.pc : '0;
                b_d = bus.imm;
            end
            T_J: begin
                a_d = bus.pc;
                b_d = LINK_STEP;
            end
            default: begin
                a_d = '0;
                b_d = '0;
            end
        endcase
    end

    // Pipeline register: reset, then flush, then capture, then drain to a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sd_q    <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (capture) begin
            valid_q <= 1'b1;
            a_q     <= a_d;
            b_q     <= b_d;
            sd_q    <= r2;
        end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready     = ready;
    assign bus.hazard_stall = stall;
    assign bus.out_valid    = valid_q;
    assign bus.a            = a_q;
    assign bus.b            = b_q;
    assign bus.store_data   = sd_q;
endmodule

// File: doc/operand_stage.md
# operand_stage

Registered, parametrised operand builder for the RISC-V core's ID/EX boundary. It selects ALU operands A/B from register data, PC, immediate or shamt according to instruction type, with EX/MEM forwarding and load-use stall detection. Results are held in a valid/ready pipeline register feeding the execute stage. It replaces the purely combinational operand selection and adds pipelining, bypass and flush behaviour.

## Interface
Parameters:
- XLEN, 32, datapath width of register data, PC, immediate and outputs (32 or 64)
- FWD_EN, 1, 1 enables EX/MEM forwarding; 0 always uses register-file data
- LOAD_STALL_EN, 1, 1 enables load-use stall detection; 0 ties hazard_stall low

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  decode stage presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- instr_type  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=N, others reserved
- shamt_used  in  1  R-type shift by immediate: B = shamt
- inc_pc  in  1  I-type: link (A=PC, B=4); U-type: AUIPC (A=PC)
- rs1, rs2  in  5  source register indices; rs2 doubles as shamt
- rs1_data, rs2_data  in  XLEN  register-file read data
- pc, imm  in  XLEN  instruction PC and sign-extended immediate
- ex_wr_en, ex_is_load  in  1  EX-stage instruction writes rd / is a load
- ex_rd  in  5 ; ex_data  in  XLEN  EX-stage destination and result
- mem_wr_en  in  1 ; mem_rd  in  5 ; mem_data  in  XLEN  MEM-stage write-back
- flush  in  1  kill the held instruction and the one being accepted
- out_valid  out  1  a, b, store_data valid for execute
- out_ready  in  1  execute consumes output this cycle
- a, b, store_data  out  XLEN  ALU operands; forwarded rs2 for SW
- hazard_stall  out  1  load-use hazard currently blocks acceptance

## Operation
- Source resolution (combinational, per source s in {rs1, rs2}):
  - If FWD_EN, s≠0, ex_wr_en and ex_rd==s: use ex_data.
  - Else if FWD_EN, s≠0, mem_wr_en and mem_rd==s: use mem_data.
  - Else: use register-file data.
  - EX beats MEM. x0 is never forwarded.
- Operand selection on resolved r1/r2:
  - R: a=r1; b=r2, or b=zero-extended rs2 when shamt_used.
  - I: inc_pc gives a=pc, b=4; otherwise a=r1, b=imm.
  - S: a=r1, b=imm.
  - B: a=r1, b=r2.
  - U: a=pc if inc_pc, else 0; b=imm.
  - J: a=pc, b=4.
  - N/reserved: a=b=0.
  - store_data=r2 for every type.
- Uses: rs1 is used by R, S, B, and by I when !inc_pc. rs2 is used by R when !shamt_used, and by S and B.
- hazard_stall = LOAD_STALL_EN & in_valid & ex_wr_en & ex_is_load & ex_rd≠0 & (ex_rd matches a used source).
- in_ready = (!out_valid | out_ready) & !hazard_stall.
- Capture: when in_valid & in_ready & !flush, the registers load a/b/store_data and out_valid←1.
- Bubble: when out_valid & out_ready and nothing is captured, out_valid←0 and the data registers hold.
- Hold: when out_valid & !out_ready, all outputs are stable.
- Flush: flush=1 gives out_valid←0 next edge and no capture that cycle. flush has priority over capture and hold.
- Reset: out_valid=0, a=b=store_data=0. in_ready is 1 after reset unless hazard_stall is asserted.

## Timing
- Latency is 1 cycle, from accepted input to out_valid/a/b.
- Throughput is 1 instruction/cycle when out_ready=1 and there is no hazard.
- in_ready and hazard_stall are combinational from inputs and out_valid. There is no combinational path from in_valid to out_valid.
- Forwarding uses the ex_*/mem_* values in the capture cycle. The result is frozen once registered and is not re-forwarded while held.
- Load-use: the stall lasts while the condition holds, typically 1 cycle. Execute receives a bubble (out_valid=0) that cycle if it consumed the previous output.
- If rst and flush are asserted together, rst wins and the result is the same state.

## Test plan
- Reset, then R-type: rs1_data=5, rs2_data=7 -> next cycle out_valid=1, a=5, b=7. Before that: out_valid=0, a=b=0.
- Forward priority: rs1=3, ex_rd=3 ex_data=0xAA, mem_rd=3 mem_data=0xBB, ADD -> a=0xAA. With ex_wr_en=0 -> a=0xBB. With rs1=0 -> a=rs1_data.
- Load-use: ex_is_load=1, ex_rd=4, SW with rs2=4 -> hazard_stall=1, in_ready=0, one bubble. Next cycle with ex_wr_en=0 and mem_rd=4 mem_data=0x1234 -> store_data=0x1234. Same case with SLLI (shamt_used, rs2=4) -> no stall.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and a/b unchanged. Release -> next instruction appears the cycle after.
- Flush while holding and accepting -> out_valid=0 next cycle. Accepted instruction dropped. The following instruction flows normally.
- Modes: JAL pc=0x100 -> a=0x100, b=4. LUI imm=0x12345000 -> a=0, b=imm. AUIPC -> a=pc. JALR -> a=pc, b=4. SLLI rs2=5'd31 -> b=31. With XLEN=64, repeat with 64-bit data.
